// File: rtl/fanout_fifo_mc_if.sv
// Link bundle between the router input, the fan-out FIFO and its downstream channels.
// The slave view belongs to the fan-out block; the master view drives it.
interface fanout_fifo_mc_if #(
  parameter int WIDTH_DATA = 32,
  parameter int NUM_CH     = 4
);
  logic                  I_FTk_v;
  logic                  I_FTk_a;
  logic                  I_FTk_r;
  logic [WIDTH_DATA-1:0] I_FTk_d;
  logic                  O_BTk_n;
  logic [NUM_CH-1:0]     O_FTk_v;
  logic                  O_FTk_a;
  logic                  O_FTk_r;
  logic [WIDTH_DATA-1:0] O_FTk_d;
  logic [NUM_CH-1:0]     I_BTk_n;

  modport slave (
    input  I_FTk_v, I_FTk_a, I_FTk_r, I_FTk_d, I_BTk_n,
    output O_BTk_n, O_FTk_v, O_FTk_a, O_FTk_r, O_FTk_d
  );

  modport master (
    output I_FTk_v, I_FTk_a, I_FTk_r, I_FTk_d, I_BTk_n,
    input  O_BTk_n, O_FTk_v, O_FTk_a, O_FTk_r, O_FTk_d
  );
endinterface

// File: rtl/fanout_fifo_mc.sv
// Multicast fan-out link element: buffers messages in a FIFO and broadcasts each one
// to the channel subset named in its header, discarding zero-mask messages.
module fanout_fifo_mc #(
  parameter int WIDTH_DATA   = 32,
  parameter int WIDTH_LENGTH = 8,
  parameter int NUM_CH       = 4,
  parameter int DEPTH_FIFO   = 12,
  parameter int THRESHOLD    = DEPTH_FIFO / 2
) (
  input  logic                               clock,
  input  logic                               reset,
  fanout_fifo_mc_if.slave                    link,
  output logic [NUM_CH-1:0]                  O_Grt,
  output logic                               O_Busy,
  output logic                               O_Ovf,
  output logic [$clog2(DEPTH_FIFO+1)-1:0]    O_Count
);

  localparam int PTR_W = (DEPTH_FIFO > 1) ? $clog2(DEPTH_FIFO) : 1;
  localparam int CNT_W = $clog2(DEPTH_FIFO + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH_FIFO);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESHOLD);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH_FIFO - 1);

  typedef enum logic [1:0] {IDLE, SEND, DROP} state_e;

  // Each entry keeps the header flag alongside the word so the FSM can spot message starts.
  logic [WIDTH_DATA:0]     mem_q [DEPTH_FIFO];
  logic [PTR_W-1:0]        wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]        rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  state_e                  state_q, state_d;
  logic [NUM_CH-1:0]       mask_q, mask_d;
  logic [WIDTH_LENGTH-1:0] len_q, len_d;
  logic [WIDTH_LENGTH-1:0] wordCnt_q, wordCnt_d;
  logic [NUM_CH-1:0]       grant_q, grant_d;
  logic                    nack_q;
  logic                    ovf_q;

  logic                    push;
  logic                    pop;
  logic                    empty;
  logic                    headA;
  logic [WIDTH_DATA-1:0]   headWord;
  logic [NUM_CH-1:0]       hdrMask;
  logic [WIDTH_LENGTH-1:0] hdrLen;
  logic                    sending;

  assign empty    = (count_q == '0);
  assign headA    = mem_q[rdPtr_q][WIDTH_DATA];
  assign headWord = mem_q[rdPtr_q][WIDTH_DATA-1:0];
  assign hdrMask  = headWord[NUM_CH-1:0];
  assign hdrLen   = headWord[NUM_CH+WIDTH_LENGTH-1:NUM_CH];
  assign sending  = (state_q == SEND);

  // Message sequencing; the word counter runs 0..L in SEND and 1..L in DROP.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    len_d     = len_q;
    wordCnt_d = wordCnt_q;
    grant_d   = '0;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (headA && (hdrMask != '0)) begin
            state_d   = SEND;
            mask_d    = hdrMask;
            len_d     = hdrLen;
            wordCnt_d = '0;
            grant_d   = hdrMask;
          end else if (headA) begin
            pop       = 1'b1;
            len_d     = hdrLen;
            wordCnt_d = WIDTH_LENGTH'(1);
            if (hdrLen != '0) begin
              state_d = DROP;
            end
          end else begin
            pop = 1'b1;
          end
        end
      end
      SEND: begin
        if (!empty && ((link.I_BTk_n & mask_q) == '0)) begin
          pop = 1'b1;
          if (wordCnt_q == len_q) begin
            state_d = IDLE;
          end else begin
            wordCnt_d = wordCnt_q + 1'b1;
          end
        end
      end
      DROP: begin
        if (!empty) begin
          pop = 1'b1;
          if (wordCnt_q == len_q) begin
            state_d = IDLE;
          end else begin
            wordCnt_d = wordCnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  always_comb begin
    push    = link.I_FTk_v && ((count_q != DEPTH_C) || pop);
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      mask_q    <= '0;
      len_q     <= '0;
      wordCnt_q <= '0;
      grant_q   <= '0;
      nack_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      mask_q    <= mask_d;
      len_q     <= len_d;
      wordCnt_q <= wordCnt_d;
      grant_q   <= grant_d;
      nack_q    <= (count_d >= THRESH_C);
      ovf_q     <= ovf_q | (link.I_FTk_v & ~push);
    end
  end

  // Storage needs no reset: the read side is gated by the occupancy count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wrPtr_q] <= {link.I_FTk_a, link.I_FTk_d};
    end
  end

  assign link.O_BTk_n = nack_q;
  assign link.O_FTk_v = sending ? (mask_q & {NUM_CH{!empty}}) : '0;
  assign link.O_FTk_a = sending && (wordCnt_q == '0);
  assign link.O_FTk_r = sending && (wordCnt_q == len_q);
  assign link.O_FTk_d = sending ? headWord : '0;

  assign O_Grt   = grant_q;
  assign O_Busy  = (state_q != IDLE);
  assign O_Ovf   = ovf_q;
  assign O_Count = count_q;

endmodule

// File: tb/tb_fanout_fifo_mc.sv
// Directed bench for fanout_fifo_mc: a cycle table for multicast, stall and discard,
// plus hand-written sequences for streaming, wrap-around, overflow and reset.
module tb_fanout_fifo_mc;

  logic       clock;
  logic       reset;
  logic [3:0] O_Grt;
  logic       O_Busy;
  logic       O_Ovf;
  logic [3:0] O_Count;
  logic [48:0] obs;
  int testsRun;
  int testsFailed;

  fanout_fifo_mc_if #(.WIDTH_DATA(32), .NUM_CH(4)) link ();

  fanout_fifo_mc #(
    .WIDTH_DATA(32), .WIDTH_LENGTH(8), .NUM_CH(4), .DEPTH_FIFO(12), .THRESHOLD(6)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .link    (link.slave),
    .O_Grt   (O_Grt),
    .O_Busy  (O_Busy),
    .O_Ovf   (O_Ovf),
    .O_Count (O_Count)
  );

  assign obs = {link.O_FTk_v, link.O_FTk_a, link.O_FTk_r, link.O_FTk_d,
                O_Grt, O_Busy, link.O_BTk_n, O_Count, O_Ovf};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        v;
    logic        a;
    logic [31:0] d;
    logic [3:0]  nack;
    logic [48:0] exp;
  } vec_t;

  vec_t vecs [21];

  function automatic logic [48:0] packExp(logic [3:0] v, logic a, logic r, logic [31:0] d,
                                          logic [3:0] grt, logic busy, logic bp,
                                          logic [3:0] cnt, logic ovf);
    return {v, a, r, d, grt, busy, bp, cnt, ovf};
  endfunction

  function automatic vec_t mkVec(logic v, logic a, logic [31:0] d, logic [3:0] nack,
                                 logic [48:0] exp);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.nack = nack; t.exp = exp;
    return t;
  endfunction

  function automatic logic [31:0] longWord(int k);
    return (k == 0) ? 32'h0000_0279 : 32'h0000_1000 + 32'(k);
  endfunction

  function automatic logic [3:0] unitMask(int k);
    return 4'((k % 15) + 1);
  endfunction

  function automatic logic [31:0] unitWord(int k);
    return (32'(k + 1) << 16) | 32'(unitMask(k));
  endfunction

  // Drive one word (or idle) and advance to just after the next rising edge.
  task automatic applyStimulus(input logic v, input logic a, input logic [31:0] d,
                               input logic [3:0] nack);
    link.I_FTk_v = v;
    link.I_FTk_a = a;
    link.I_FTk_r = v;
    link.I_FTk_d = d;
    link.I_BTk_n = nack;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pulseReset(input string name);
    reset = 1'b0;
    #1;
    checkOutput(name, 64'(obs), 64'(0));
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int outIdx;
    int sentIdx;
    logic [3:0] cnt;

    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b0;
    link.I_FTk_v = 1'b0;
    link.I_FTk_a = 1'b0;
    link.I_FTk_r = 1'b0;
    link.I_FTk_d = '0;
    link.I_BTk_n = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_state", 64'(obs), 64'(0));
    reset = 1'b1;

    // Multicast mask 0101 L=3, the same message with a stall, then a zero-mask discard.
    vecs[0]  = mkVec(1, 1, 32'h35, 4'h0, packExp(4'h0, 0, 0, 32'h0,  4'h0, 0, 0, 4'd1, 0));
    vecs[1]  = mkVec(1, 0, 32'hA,  4'h0, packExp(4'h5, 1, 0, 32'h35, 4'h5, 1, 0, 4'd2, 0));
    vecs[2]  = mkVec(1, 0, 32'hB,  4'h0, packExp(4'h5, 0, 0, 32'hA,  4'h0, 1, 0, 4'd2, 0));
    vecs[3]  = mkVec(1, 0, 32'hC,  4'h0, packExp(4'h5, 0, 0, 32'hB,  4'h0, 1, 0, 4'd2, 0));
    vecs[4]  = mkVec(0, 0, 32'h0,  4'h0, packExp(4'h5, 0, 1, 32'hC,  4'h0, 1, 0, 4'd1, 0));
    vecs[5]  = mkVec(0, 0, 32'h0,  4'h0, packExp(4'h0, 0, 0, 32'h0,  4'h0, 0, 0, 4'd0, 0));
    vecs[6]  = mkVec(1, 1, 32'h35, 4'h0, packExp(4'h0, 0, 0, 32'h0,  4'h0, 0, 0, 4'd1, 0));
    vecs[7]  = mkVec(1, 0, 32'hA,  4'h0, packExp(4'h5, 1, 0, 32'h35, 4'h5, 1, 0, 4'd2, 0));
    vecs[8]  = mkVec(1, 0, 32'hB,  4'h0, packExp(4'h5, 0, 0, 32'hA,  4'h0, 1, 0, 4'd2, 0));
    vecs[9]  = mkVec(1, 0, 32'hC,  4'h4, packExp(4'h5, 0, 0, 32'hA,  4'h0, 1, 0, 4'd3, 0));
    vecs[10] = mkVec(0, 0, 32'h0,  4'h4, packExp(4'h5, 0, 0, 32'hA,  4'h0, 1, 0, 4'd3, 0));
    vecs[11] = mkVec(0, 0, 32'h0,  4'h4, packExp(4'h5, 0, 0, 32'hA,  4'h0, 1, 0, 4'd3, 0));
    vecs[12] = mkVec(0, 0, 32'h0,  4'h8, packExp(4'h5, 0, 0, 32'hB,  4'h0, 1, 0, 4'd2, 0));
    vecs[13] = mkVec(0, 0, 32'h0,  4'h8, packExp(4'h5, 0, 1, 32'hC,  4'h0, 1, 0, 4'd1, 0));
    vecs[14] = mkVec(0, 0, 32'h0,  4'h0, packExp(4'h0, 0, 0, 32'h0,  4'h0, 0, 0, 4'd0, 0));
    vecs[15] = mkVec(1, 1, 32'h20, 4'h0, packExp(4'h0, 0, 0, 32'h0,  4'h0, 0, 0, 4'd1, 0));
    vecs[16] = mkVec(1, 0, 32'h11, 4'h0, packExp(4'h0, 0, 0, 32'h0,  4'h0, 1, 0, 4'd1, 0));
    vecs[17] = mkVec(1, 0, 32'h22, 4'h0, packExp(4'h0, 0, 0, 32'h0,  4'h0, 1, 0, 4'd1, 0));
    vecs[18] = mkVec(1, 1, 32'h02, 4'h0, packExp(4'h0, 0, 0, 32'h0,  4'h0, 0, 0, 4'd1, 0));
    vecs[19] = mkVec(0, 0, 32'h0,  4'h0, packExp(4'h2, 1, 1, 32'h02, 4'h2, 1, 0, 4'd1, 0));
    vecs[20] = mkVec(0, 0, 32'h0,  4'h0, packExp(4'h0, 0, 0, 32'h0,  4'h0, 0, 0, 4'd0, 0));

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].nack);
      checkOutput($sformatf("vec%0d", i), 64'(obs), 64'(vecs[i].exp));
    end

    // One 40-word message streamed back to back: occupancy is flat while push and pop overlap.
    outIdx = 0;
    for (int c = 1; c <= 100 && outIdx < 40; c++) begin
      if (c <= 40) applyStimulus(1'b1, c == 1, longWord(c - 1), 4'h0);
      else         applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);
      if (c >= 3 && c <= 40) checkOutput($sformatf("steady_count%0d", c), 64'(O_Count), 64'd2);
      if (link.O_FTk_v != 4'h0) begin
        checkOutput($sformatf("long_out%0d", outIdx),
                    64'({link.O_FTk_v, link.O_FTk_a, link.O_FTk_r, link.O_FTk_d}),
                    64'({4'h9, outIdx == 0, outIdx == 39, longWord(outIdx)}));
        outIdx++;
      end
    end
    checkOutput("long_done", 64'(outIdx), 64'd40);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);
    checkOutput("long_drained", 64'({O_Count, O_Busy}), 64'({4'd0, 1'b0}));

    // Forty unit-length messages with the sender honouring back-pressure; order must hold.
    outIdx  = 0;
    sentIdx = 0;
    for (int c = 0; c < 400 && outIdx < 40; c++) begin
      if (sentIdx < 40 && !link.O_BTk_n) begin
        applyStimulus(1'b1, 1'b1, unitWord(sentIdx), 4'h0);
        sentIdx++;
      end else begin
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);
      end
      if (link.O_FTk_v != 4'h0) begin
        checkOutput($sformatf("unit_out%0d", outIdx),
                    64'({link.O_FTk_v, link.O_FTk_a, link.O_FTk_r, link.O_FTk_d}),
                    64'({unitMask(outIdx), 1'b1, 1'b1, unitWord(outIdx)}));
        outIdx++;
      end
    end
    checkOutput("unit_done", 64'(outIdx), 64'd40);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);
    checkOutput("unit_drained", 64'({O_Count, O_Busy, O_Ovf}), 64'({4'd0, 1'b0, 1'b0}));

    // All channels nacked: fill to 12, the 13th word is dropped and overflow sticks.
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(1'b1, k == 1, (k == 1) ? 32'h14F : 32'h2000 + 32'(k), 4'hF);
      cnt = (k < 12) ? 4'(k) : 4'd12;
      checkOutput($sformatf("fill%0d", k), 64'({O_Count, link.O_BTk_n, O_Ovf}),
                  64'({cnt, cnt >= 4'd6, k == 13}));
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 4'hF);
      checkOutput($sformatf("ovf_sticky%0d", k), 64'({O_Count, O_Ovf}), 64'({4'd12, 1'b1}));
    end
    pulseReset("ovf_reset");

    // Reset in the middle of a 5-word message, then a unit message to mask 0010.
    applyStimulus(1'b1, 1'b1, 32'h4F, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h3001, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h3002, 4'h0);
    checkOutput("mid_busy", 64'({O_Busy, O_Count}), 64'({1'b1, 4'd2}));
    pulseReset("mid_reset");
    applyStimulus(1'b1, 1'b1, 32'h02, 4'h0);
    checkOutput("post_hdr", 64'({link.O_FTk_v, O_Count}), 64'({4'h0, 4'd1}));
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);
    checkOutput("post_send", 64'(obs), 64'(packExp(4'h2, 1, 1, 32'h02, 4'h2, 1, 0, 4'd1, 0)));
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);
    checkOutput("post_idle", 64'(obs), 64'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
